// File: rtl/decryption_dispatcher.sv
// ----------------------------------------------------------------------------
// Module      : decryption_dispatcher
// Description : Routes each encrypted message to one of three decryption
//               engines, runs the token/busy handshake and muxes the result.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module decryption_dispatcher #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
  parameter int                 START_TIMEOUT          = 16,
  parameter int                 CNT_WIDTH              = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [1:0]           sel_i,
  output logic                 busy_o,
  output logic [D_WIDTH-1:0]   eng_data_o,
  output logic [2:0]           eng_valid_o,
  input  logic [2:0]           eng_busy_i,
  input  logic [3*D_WIDTH-1:0] eng_data_i,
  input  logic [2:0]           eng_valid_i,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [CNT_WIDTH-1:0] c_max_chars    = CNT_WIDTH'(MAX_NOF_CHARS);
  localparam logic [CNT_WIDTH-1:0] c_timeout_last = CNT_WIDTH'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FORWARD    = 2'd1,
    WAIT_START = 2'd2,
    DRAIN      = 2'd3
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sel_q;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_tcnt;
  logic [D_WIDTH-1:0]   r_eng_data;
  logic [2:0]           r_eng_valid;
  logic [D_WIDTH-1:0]   r_data_o;
  logic                 r_valid_o;
  logic                 r_done;
  logic                 r_err;

  logic                 w_is_token;
  logic                 w_eng_busy;
  logic                 w_eng_valid;
  logic [D_WIDTH-1:0]   w_eng_data;

  function automatic logic [2:0] f_onehot(input logic [1:0] s);
    case (s)
      2'd0:    f_onehot = 3'b001;
      2'd1:    f_onehot = 3'b010;
      2'd2:    f_onehot = 3'b100;
      default: f_onehot = 3'b000;
    endcase
  endfunction

  assign w_is_token = (data_i == START_DECRYPTION_TOKEN);

  // Engine-side mux keyed by the select latched at message start
  always_comb begin
    w_eng_busy  = 1'b0;
    w_eng_valid = 1'b0;
    w_eng_data  = '0;
    case (r_sel_q)
      2'd0: begin
        w_eng_busy  = eng_busy_i[0];
        w_eng_valid = eng_valid_i[0];
        w_eng_data  = eng_data_i[0*D_WIDTH +: D_WIDTH];
      end
      2'd1: begin
        w_eng_busy  = eng_busy_i[1];
        w_eng_valid = eng_valid_i[1];
        w_eng_data  = eng_data_i[1*D_WIDTH +: D_WIDTH];
      end
      2'd2: begin
        w_eng_busy  = eng_busy_i[2];
        w_eng_valid = eng_valid_i[2];
        w_eng_data  = eng_data_i[2*D_WIDTH +: D_WIDTH];
      end
      default: begin
        w_eng_busy  = 1'b0;
        w_eng_valid = 1'b0;
        w_eng_data  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel_q     <= 2'd0;
      r_cnt       <= '0;
      r_tcnt      <= '0;
      r_eng_data  <= '0;
      r_eng_valid <= 3'b000;
      r_data_o    <= '0;
      r_valid_o   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_eng_valid <= 3'b000;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_valid_o   <= 1'b0;
      r_data_o    <= '0;

      if (r_state != IDLE) begin
        r_valid_o <= w_eng_valid;
        r_data_o  <= w_eng_valid ? w_eng_data : '0;
      end

      case (r_state)
        IDLE: begin
          // A lone token in IDLE is silently discarded
          if (valid_i && !w_is_token) begin
            if (sel_i == 2'd3) begin
              r_err <= 1'b1;
            end else begin
              r_sel_q     <= sel_i;
              r_cnt       <= CNT_WIDTH'(1);
              r_eng_data  <= data_i;
              r_eng_valid <= f_onehot(sel_i);
              r_state     <= FORWARD;
            end
          end
        end

        FORWARD: begin
          if (valid_i) begin
            if (w_is_token) begin
              r_eng_data  <= data_i;
              r_eng_valid <= f_onehot(r_sel_q);
              r_tcnt      <= '0;
              r_state     <= WAIT_START;
            end else if (r_cnt == c_max_chars) begin
              r_err <= 1'b1;
            end else begin
              r_eng_data  <= data_i;
              r_eng_valid <= f_onehot(r_sel_q);
              r_cnt       <= r_cnt + CNT_WIDTH'(1);
            end
          end
        end

        WAIT_START: begin
          if (valid_i) begin
            r_err <= 1'b1;
          end
          // Busy rising on the timeout cycle still counts as a start
          if (w_eng_busy) begin
            r_state <= DRAIN;
          end else if (r_tcnt == c_timeout_last) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + CNT_WIDTH'(1);
          end
        end

        DRAIN: begin
          if (valid_i) begin
            r_err <= 1'b1;
          end
          if (!w_eng_busy) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o      = (r_state == WAIT_START) || (r_state == DRAIN);
  assign eng_data_o  = r_eng_data;
  assign eng_valid_o = r_eng_valid;
  assign data_o      = r_data_o;
  assign valid_o     = r_valid_o;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

`default_nettype wire

// File: doc/decryption_dispatcher.md
Name: decryption_dispatcher

Overview:
- Front-end controller for the decryption subsystem. Accepts an encrypted character stream plus an engine select, and forwards each message to one of three decryption engines (0 caesar, 1 scytale, 2 zigzag).
- Sequences each message through the engine's START-token/busy handshake, blocks upstream while the engine works, and muxes the selected engine's output back onto one output stream.
- Sits between the input interface and the three engines inside the decryption top level.

Parameters:
- D_WIDTH, 8, character width in bits
- MAX_NOF_CHARS, 50, maximum message length excluding the token
- START_DECRYPTION_TOKEN, 8'hFA, end-of-message / start-decryption marker
- START_TIMEOUT, 16, cycles allowed for the engine busy to rise after the token is forwarded
- CNT_WIDTH, 8, width of the character and timeout counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: synchronous, active-low; clock clk
- data_i  in  D_WIDTH  encrypted character or token
- valid_i  in  1  data_i qualifier
- sel_i  in  2  engine select; sampled on the first character of a message
- busy_o  out  1  upstream must not drive valid_i while high
- eng_data_o  out  D_WIDTH  character bus shared by all engines
- eng_valid_o  out  3  one-hot valid toward engine[sel]
- eng_busy_i  in  3  engine busy flags
- eng_data_i  in  3*D_WIDTH  engine outputs; engine k occupies slice [k*D_WIDTH +: D_WIDTH]
- eng_valid_i  in  3  engine output valids
- data_o  out  D_WIDTH  decrypted character
- valid_o  out  1  data_o qualifier
- done_o  out  1  one-cycle pulse at message completion
- err_o  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All outputs are 0; state=IDLE; counters and latched select are 0.
  - Reset mid-message aborts the message with no done_o pulse.
- States: IDLE, FORWARD, WAIT_START, DRAIN.
- IDLE:
  - valid_i with a non-token character: latch sel_i into sel_q, n=1, forward the character, go to FORWARD.
  - valid_i with the token: ignored, no error.
  - sel_i=3 on the first character: character dropped, err_o pulses, stay IDLE.
- Forwarding timing:
  - Registered, one-cycle latency: eng_data_o=data_i and eng_valid_o=(1<<sel_q) in the cycle after acceptance.
  - eng_valid_o is 0 in all other cycles.
- FORWARD:
  - Non-token with n<MAX_NOF_CHARS: forward it, n++.
  - Non-token with n==MAX_NOF_CHARS: character dropped, err_o pulses, stay FORWARD.
  - Token: forward it, clear timeout counter, go to WAIT_START.
  - sel_i is ignored until the next message.
- WAIT_START:
  - busy_o=1; timeout counter increments each cycle.
  - eng_busy_i[sel_q]=1: go to DRAIN.
  - Counter reaches START_TIMEOUT: err_o pulses, go to IDLE with no done_o.
- DRAIN:
  - busy_o=1.
  - eng_busy_i[sel_q] falls to 0: done_o pulses in the next cycle, go to IDLE.
- busy_o is combinational from state: 1 in WAIT_START and DRAIN, else 0.
- valid_i while busy_o=1: input dropped, err_o pulses, state unchanged.
- Output mux:
  - Registered, one-cycle latency: valid_o=eng_valid_i[sel_q] and data_o=slice[sel_q], sampled in FORWARD, WAIT_START and DRAIN.
  - Other engines' valids are ignored.
  - data_o=0 whenever valid_o=0.
- A message accepted in the done_o cycle (state already IDLE) is legal.
- Simultaneous events:
  - Timeout and busy rise in the same cycle: busy wins, go to DRAIN.
  - Drop error and another error in the same cycle: a single err_o pulse.

Test Plan:
- sel_i=2, chars 'A','B','C', then 8'hFA; model engine asserts busy 1 cycle after the token and emits 'A','C','B' -> eng_valid_o=3'b100 for 4 cycles (4th carries 8'hFA); data_o shows 'A','C','B' one cycle after each eng_valid_i; done_o pulses once; busy_o high from WAIT_START until done.
- sel_i=0, 51 chars then token -> first 50 forwarded; 51st drops with one err_o pulse; token still forwarded.
- sel_i=1, 2 chars + token; engine never asserts busy -> err_o pulses exactly START_TIMEOUT (16) cycles after entering WAIT_START; back to IDLE; no done_o.
- valid_i=1 during DRAIN -> char dropped, err_o pulses, eng_valid_o stays 0; message completes normally.
- sel_i=3 on first char -> err_o pulses, eng_valid_o=0; following token ignored with no err_o.
- rst_n=0 during DRAIN -> next cycle all outputs 0, state IDLE; new message with sel_i=0 then proceeds normally.
